// File: rtl/matrix_row_scanner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_pkg : shared sizes, scan FSM encoding and row decode helper    |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  function automatic logic [ROWS-1:0] row_onehot(input logic [2:0] row);
    return ROWS'(1) << row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_row_scanner_timebase.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_timebase : per-slot tick counter and row counter with strobes    |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module scan_timebase #(
  parameter int ROW_TICKS   = 2000,
  parameter int BLANK_TICKS = 50
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       i_clear,
  output logic [2:0] o_row,
  output logic       o_slot_end,
  output logic       o_frame_end,
  output logic       o_blank_end
);

  localparam int TW = $clog2(ROW_TICKS);
  localparam logic [TW-1:0] c_last_tick = TW'(ROW_TICKS - 1);

  logic [TW-1:0] r_tick;
  logic [2:0]    r_row;
  logic          w_slot_end;

  assign w_slot_end  = !i_clear && (r_tick == c_last_tick);
  assign o_slot_end  = w_slot_end;
  assign o_frame_end = w_slot_end && (r_row == 3'd7);
  assign o_row       = r_row;

  // With no blanking the slot starts straight in DRIVE, so there is no strobe.
  if (BLANK_TICKS > 0) begin : g_blank
    localparam logic [TW-1:0] c_blank_last = TW'(BLANK_TICKS - 1);
    assign o_blank_end = !i_clear && (r_tick == c_blank_last);
  end else begin : g_no_blank
    assign o_blank_end = 1'b0;
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_tick <= '0;
      r_row  <= '0;
    end else if (i_clear) begin
      r_tick <= '0;
      r_row  <= '0;
    end else if (w_slot_end) begin
      r_tick <= '0;
      r_row  <= r_row + 3'd1;
    end else begin
      r_tick <= r_tick + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_row_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_row_scanner : 8x8 LED matrix row scan with frame-synchronous   |
// | shadow buffer, anti-ghost blanking and 8-level PWM brightness         |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module matrix_row_scanner
  import matrix_pkg::*;
#(
  parameter int ROW_TICKS      = 2000,
  parameter int BLANK_TICKS    = 50,
  parameter bit ROW_ACTIVE_LOW = 1'b1,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       en,
  input  logic [2:0] brightness,
  input  logic [7:0] map0,
  input  logic [7:0] map1,
  input  logic [7:0] map2,
  input  logic [7:0] map3,
  input  logic [7:0] map4,
  input  logic [7:0] map5,
  input  logic [7:0] map6,
  input  logic [7:0] map7,
  output logic [7:0] row_sel,
  output logic [7:0] col,
  output logic       frame_done
);

  localparam state_t c_slot_start = (BLANK_TICKS == 0) ? DRIVE : BLANK;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [ROWS-1:0][COLS-1:0]    r_shadow;
  logic [ROWS-1:0][COLS-1:0]    w_map;
  logic [2:0]                   r_bri;
  logic [2:0]                   r_pwm;
  logic [ROWS-1:0]              r_row_drv;
  logic [COLS-1:0]              r_col_drv;
  logic                         r_frame_done;

  logic       w_clear;
  logic       w_load;
  logic       w_drive;
  logic       w_pwm_clr;
  logic [2:0] w_row;
  logic       w_slot_end;
  logic       w_frame_end;
  logic       w_blank_end;

  assign w_map   = {map7, map6, map5, map4, map3, map2, map1, map0};
  assign w_clear = !en || (r_state == OFF);

  scan_timebase #(
    .ROW_TICKS   (ROW_TICKS),
    .BLANK_TICKS (BLANK_TICKS)
  ) u_timebase (
    .CLK         (CLK),
    .CLR         (CLR),
    .i_clear     (w_clear),
    .o_row       (w_row),
    .o_slot_end  (w_slot_end),
    .o_frame_end (w_frame_end),
    .o_blank_end (w_blank_end)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= OFF;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = OFF;
    end else begin
      case (r_state)
        OFF:     w_state_nxt = c_slot_start;
        BLANK:   if (w_blank_end) w_state_nxt = DRIVE;
        DRIVE:   if (w_slot_end)  w_state_nxt = c_slot_start;
        default: w_state_nxt = OFF;
      endcase
    end
  end

  // Shadow only refreshes at scan start or frame boundary to avoid tearing.
  assign w_load = en && ((r_state == OFF) || w_frame_end);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_shadow <= '0;
      r_bri    <= '0;
    end else if (w_load) begin
      r_shadow <= w_map;
      r_bri    <= brightness;
    end
  end

  assign w_pwm_clr = (w_state_nxt == DRIVE) && ((r_state != DRIVE) || w_slot_end);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)                    r_pwm <= '0;
    else if (w_pwm_clr)          r_pwm <= '0;
    else if (r_state == DRIVE)   r_pwm <= r_pwm + 3'd1;
  end

  // Gating with en makes the pins go dark on the very edge that sees en low.
  assign w_drive = en && (r_state == DRIVE);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_row_drv    <= '0;
      r_col_drv    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_row_drv    <= w_drive ? row_onehot(w_row) : '0;
      r_col_drv    <= (w_drive && (r_pwm <= r_bri)) ? r_shadow[w_row] : '0;
      r_frame_done <= w_frame_end;
    end
  end

  assign row_sel    = r_row_drv ^ {ROWS{ROW_ACTIVE_LOW}};
  assign col        = r_col_drv ^ {COLS{COL_ACTIVE_LOW}};
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_row_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matrix_row_scanner : scoreboard bench for matrix_row_scanner       |
// | Revision              : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_matrix_row_scanner;

  localparam int ROW_TICKS   = 16;
  localparam int BLANK_TICKS = 2;
  localparam int FRAME       = 8 * ROW_TICKS;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       en  = 1'b0;
  logic [2:0] brightness = 3'd0;
  logic [7:0] map0 = 8'h00, map1 = 8'h00, map2 = 8'h00, map3 = 8'h00;
  logic [7:0] map4 = 8'h00, map5 = 8'h00, map6 = 8'h00, map7 = 8'h00;
  logic [7:0] row_sel;
  logic [7:0] col;
  logic       frame_done;

  always #5 CLK = ~CLK;

  matrix_row_scanner #(
    .ROW_TICKS      (ROW_TICKS),
    .BLANK_TICKS    (BLANK_TICKS),
    .ROW_ACTIVE_LOW (1'b1),
    .COL_ACTIVE_LOW (1'b0)
  ) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .en         (en),
    .brightness (brightness),
    .map0       (map0),
    .map1       (map1),
    .map2       (map2),
    .map3       (map3),
    .map4       (map4),
    .map5       (map5),
    .map6       (map6),
    .map7       (map7),
    .row_sel    (row_sel),
    .col        (col),
    .frame_done (frame_done)
  );

  typedef struct {
    int         n;
    logic [7:0] rs;
    logic [7:0] cl;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lit_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_maps(input logic [7:0][7:0] m);
    map0 = m[0]; map1 = m[1]; map2 = m[2]; map3 = m[3];
    map4 = m[4]; map5 = m[5]; map6 = m[6]; map7 = m[7];
  endtask

  // Expected pins after the n-th edge counted from the OFF->BLANK edge (n=0).
  function automatic void push_exp(input int n, input logic [7:0][7:0] sh, input logic [2:0] bri);
    exp_t       e;
    logic [7:0] one;
    int         m, t, r, p;
    one  = 8'd1;
    e.n  = n;
    e.rs = 8'hFF;
    e.cl = 8'h00;
    e.fd = 1'b0;
    if (n > 0) begin
      m    = n - 1;
      t    = m % ROW_TICKS;
      r    = (m / ROW_TICKS) % 8;
      e.fd = ((m % FRAME) == FRAME - 1);
      if (t >= BLANK_TICKS) begin
        e.rs = ~(one << r);
        p    = (t - BLANK_TICKS) % 8;
        if (p <= int'(bri)) e.cl = sh[r];
      end
    end
    sb.push_back(e);
  endfunction

  task automatic step(input int cnt);
    repeat (cnt) @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int cnt);
    exp_t e;
    check_val("sb_depth", 32'(sb.size() >= cnt), 32'd1);
    for (int i = 0; i < cnt; i++) begin
      @(posedge CLK);
      #1;
      if (sb.size() == 0) break;
      e = sb.pop_front();
      if (col == 8'hFF) lit_cnt++;
      check_val($sformatf("row_sel n=%0d", e.n), 32'(row_sel), 32'(e.rs));
      check_val($sformatf("col n=%0d", e.n), 32'(col), 32'(e.cl));
      check_val($sformatf("frame_done n=%0d", e.n), 32'(frame_done), 32'(e.fd));
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_row_sel"}, 32'(row_sel), 32'hFF);
    check_val({tag, "_col"}, 32'(col), 32'h00);
    check_val({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  task automatic restart();
    en = 1'b0;
    step(1);
    check_idle("off");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0][7:0] sh_a;
    logic [7:0][7:0] sh_b;

    // Reset held with en=1, then first slot of row 0.
    sh_a = '0;
    sh_a[0] = 8'hF0;
    set_maps(sh_a);
    brightness = 3'd7;
    en  = 1'b1;
    CLR = 1'b0;
    step(3);
    check_idle("reset");
    @(negedge CLK) CLR = 1'b1;
    for (int n = 0; n <= 20; n++) push_exp(n, sh_a, 3'd7);
    drain(21);

    // Two full frames; map3 written during row 1 only shows in frame 2.
    restart();
    for (int i = 0; i < 8; i++) sh_a[i] = 8'd1 << i;
    sh_a[3] = 8'h00;
    sh_b    = sh_a;
    sh_b[3] = 8'hFF;
    set_maps(sh_a);
    brightness = 3'd7;
    en = 1'b1;
    for (int n = 0; n <= 2 * FRAME; n++) push_exp(n, (n <= FRAME) ? sh_a : sh_b, 3'd7);
    drain(20);
    map3 = 8'hFF;
    drain(2 * FRAME + 1 - 20);

    // PWM duty at brightness 0 and 3 over row 0's 14-cycle drive window.
    restart();
    sh_a = '0;
    sh_a[0] = 8'hFF;
    set_maps(sh_a);
    brightness = 3'd0;
    en = 1'b1;
    lit_cnt = 0;
    for (int n = 0; n <= 17; n++) push_exp(n, sh_a, 3'd0);
    drain(18);
    check_val("bri0_lit_cycles", 32'(lit_cnt), 32'd2);
    restart();
    brightness = 3'd3;
    en = 1'b1;
    lit_cnt = 0;
    for (int n = 0; n <= 17; n++) push_exp(n, sh_a, 3'd3);
    drain(18);
    check_val("bri3_lit_cycles", 32'(lit_cnt), 32'd8);

    // en dropped mid-DRIVE on row 5, then restart with new maps.
    restart();
    for (int i = 0; i < 8; i++) sh_a[i] = 8'd1 << i;
    set_maps(sh_a);
    brightness = 3'd7;
    en = 1'b1;
    for (int n = 0; n <= 85; n++) push_exp(n, sh_a, 3'd7);
    drain(86);
    en = 1'b0;
    step(1);
    check_idle("en_off_row5");
    for (int i = 0; i < 8; i++) sh_b[i] = ~(8'd1 << i);
    set_maps(sh_b);
    en = 1'b1;
    for (int n = 0; n <= 40; n++) push_exp(n, sh_b, 3'd7);
    drain(41);

    // en dropped exactly on the frame-boundary edge suppresses frame_done.
    restart();
    set_maps(sh_a);
    en = 1'b1;
    for (int n = 0; n < FRAME; n++) push_exp(n, sh_a, 3'd7);
    drain(FRAME);
    en = 1'b0;
    step(1);
    check_idle("en_off_boundary");

    // Asynchronous reset between edges, then the reset scenario again.
    restart();
    sh_a = '0;
    sh_a[0] = 8'hF0;
    set_maps(sh_a);
    en = 1'b1;
    for (int n = 0; n <= 10; n++) push_exp(n, sh_a, 3'd7);
    drain(11);
    #2 CLR = 1'b0;
    #1;
    check_idle("async_reset");
    step(2);
    check_idle("async_reset_held");
    @(negedge CLK) CLR = 1'b1;
    for (int n = 0; n <= 20; n++) push_exp(n, sh_a, 3'd7);
    drain(21);

    check_val("sb_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
